// File: rtl/lcd_rx_monitor_if.sv
// Pixel-bus bundle for lcd_rx_monitor: LCD input side plus pixel stream and frame statistics.
// The master modport drives the LCD bus and observes results; the slave modport is the monitor.
interface lcd_rx_monitor_if;
  logic        lcd_de;
  logic        lcd_hs;
  logic        lcd_vs;
  logic [23:0] lcd_rgb;

  logic        pix_valid;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [23:0] pix_data;

  logic        frame_done;
  logic [11:0] frame_lines;
  logic [11:0] line_len;
  logic        err_hlen;
  logic        err_vlen;
  logic        err_sync;
  logic [23:0] frame_sum;

  modport master (
    output lcd_de, lcd_hs, lcd_vs, lcd_rgb,
    input  pix_valid, pix_x, pix_y, pix_data,
    input  frame_done, frame_lines, line_len, err_hlen, err_vlen, err_sync, frame_sum
  );

  modport slave (
    input  lcd_de, lcd_hs, lcd_vs, lcd_rgb,
    output pix_valid, pix_x, pix_y, pix_data,
    output frame_done, frame_lines, line_len, err_hlen, err_vlen, err_sync, frame_sum
  );
endinterface

// File: rtl/lcd_rx_monitor.sv
// Receive-side monitor for a parallel RGB LCD bus: pixel re-timing plus per-frame geometry checks.
// Optional frame checksum is built when LCD_RX_CHECKSUM_EN is defined; otherwise frame_sum is 0.
module lcd_rx_monitor #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  lcd_rx_monitor_if.slave bus
);

  localparam logic [0:0]  StWaitVs  = 1'b0;
  localparam logic [0:0]  StInFrame = 1'b1;
  localparam logic [11:0] CntMax    = 12'hFFF;
  localparam logic [11:0] HActive   = 12'(H_ACTIVE);
  localparam logic [11:0] VActive   = 12'(V_ACTIVE);

  logic        de_d1_q, hs_d1_q, vs_d1_q, de_d2_q, vs_d2_q;
  logic [23:0] rgb_d1_q;

  logic [0:0]  state_q, state_d;
  logic [11:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic        hlen_q, hlen_d, sync_q, sync_d;

  logic        pix_valid_q, pix_valid_d;
  logic [11:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic        frame_done_q, frame_done_d;
  logic [11:0] frame_lines_q, frame_lines_d, line_len_q, line_len_d;
  logic        err_hlen_q, err_hlen_d, err_vlen_q, err_vlen_d, err_sync_q, err_sync_d;

  logic        hs_act, vs_act, vs_prev_act, vs_lead, de_fall, line_close;
  logic        hlen_now, sync_now, frame_end, pix_take;
  logic [11:0] x_inc, y_inc, close_len, lines_now;

  // Sync delay lines reset to their inactive level so release never fakes a VS edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_d1_q  <= 1'b0;
      hs_d1_q  <= ~HS_POL;
      vs_d1_q  <= ~VS_POL;
      rgb_d1_q <= '0;
      de_d2_q  <= 1'b0;
      vs_d2_q  <= ~VS_POL;
    end else begin
      de_d1_q  <= bus.lcd_de;
      hs_d1_q  <= bus.lcd_hs;
      vs_d1_q  <= bus.lcd_vs;
      rgb_d1_q <= bus.lcd_rgb;
      de_d2_q  <= de_d1_q;
      vs_d2_q  <= vs_d1_q;
    end
  end

  assign hs_act      = (hs_d1_q == HS_POL);
  assign vs_act      = (vs_d1_q == VS_POL);
  assign vs_prev_act = (vs_d2_q == VS_POL);
  assign vs_lead     = vs_act & ~vs_prev_act;
  assign de_fall     = de_d2_q & ~de_d1_q;

  assign x_inc = (x_cnt_q == CntMax) ? CntMax : x_cnt_q + 12'd1;
  assign y_inc = (y_cnt_q == CntMax) ? CntMax : y_cnt_q + 12'd1;

  // A line still open at the VS edge is closed including the pixel sampled on that edge.
  assign line_close = de_fall | (vs_lead & de_d1_q);
  assign close_len  = de_d1_q ? x_inc : x_cnt_q;
  assign lines_now  = line_close ? y_inc : y_cnt_q;
  assign hlen_now   = hlen_q | (line_close & (close_len != HActive));
  assign sync_now   = sync_q | (de_d1_q & (hs_act | vs_act));
  assign frame_end  = (state_q == StInFrame) & vs_lead;
  assign pix_take   = (state_q == StInFrame) & de_d1_q;

  always_comb begin
    state_d       = state_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    hlen_d        = hlen_q;
    sync_d        = sync_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_data_d    = pix_data_q;
    frame_done_d  = 1'b0;
    frame_lines_d = frame_lines_q;
    line_len_d    = line_len_q;
    err_hlen_d    = err_hlen_q;
    err_vlen_d    = err_vlen_q;
    err_sync_d    = err_sync_q;

    unique case (state_q)
      StWaitVs: begin
        x_cnt_d = '0;
        y_cnt_d = '0;
        hlen_d  = 1'b0;
        sync_d  = 1'b0;
        if (vs_lead) state_d = StInFrame;
      end
      StInFrame: begin
        hlen_d = hlen_now;
        sync_d = sync_now;
        if (de_d1_q) begin
          pix_valid_d = 1'b1;
          pix_x_d     = x_cnt_q;
          pix_y_d     = y_cnt_q;
          pix_data_d  = rgb_d1_q;
          x_cnt_d     = x_inc;
        end
        if (line_close) begin
          line_len_d = close_len;
          x_cnt_d    = '0;
          y_cnt_d    = y_inc;
        end
        if (vs_lead) begin
          frame_done_d  = 1'b1;
          frame_lines_d = lines_now;
          err_hlen_d    = hlen_now;
          err_vlen_d    = (lines_now != VActive);
          err_sync_d    = sync_now;
          y_cnt_d       = '0;
          hlen_d        = 1'b0;
          sync_d        = 1'b0;
        end
      end
      default: state_d = StWaitVs;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StWaitVs;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      hlen_q        <= 1'b0;
      sync_q        <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_lines_q <= '0;
      line_len_q    <= '0;
      err_hlen_q    <= 1'b0;
      err_vlen_q    <= 1'b0;
      err_sync_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      hlen_q        <= hlen_d;
      sync_q        <= sync_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      frame_done_q  <= frame_done_d;
      frame_lines_q <= frame_lines_d;
      line_len_q    <= line_len_d;
      err_hlen_q    <= err_hlen_d;
      err_vlen_q    <= err_vlen_d;
      err_sync_q    <= err_sync_d;
    end
  end

  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.pix_data    = pix_data_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_lines = frame_lines_q;
  assign bus.line_len    = line_len_q;
  assign bus.err_hlen    = err_hlen_q;
  assign bus.err_vlen    = err_vlen_q;
  assign bus.err_sync    = err_sync_q;

`ifdef LCD_RX_CHECKSUM_EN
  logic [23:0] sum_q, sum_d, sum_now, frame_sum_q, frame_sum_d;

  assign sum_now = sum_q + (pix_take ? rgb_d1_q : 24'd0);

  always_comb begin
    sum_d       = sum_q;
    frame_sum_d = frame_sum_q;
    if (state_q == StWaitVs) begin
      sum_d = '0;
    end else if (frame_end) begin
      frame_sum_d = sum_now;
      sum_d       = '0;
    end else begin
      sum_d = sum_now;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sum_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      sum_q       <= sum_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign bus.frame_sum = frame_sum_q;
`else
  assign bus.frame_sum = '0;
`endif

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Randomised self-checking bench for lcd_rx_monitor against a sample-stream reference model
// that derives pixel coordinates, line lengths and frame statistics from the driven bus.
module tb_lcd_rx_monitor;
  localparam int unsigned HA = 8;
  localparam int unsigned VA = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lcd_rx_monitor_if bus_if ();

  lcd_rx_monitor #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .HS_POL  (1'b0),
    .VS_POL  (1'b0)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int x; int y; logic [23:0] d; } pix_t;
  typedef struct { int cyc; int len; } line_t;
  typedef struct { int cyc; int lines; bit hlen; bit vlen; bit sync; logic [23:0] sum; } frm_t;

  pix_t  pix_q[$];
  line_t line_q[$];
  frm_t  frm_q[$];

  // Reference model state: one entry per driven bus sample, no pipeline.
  bit          armed, prev_de, prev_vs_act, m_hlen, m_sync;
  int          mx, my;
  logic [23:0] m_sum;
  int          rgb_mode, pidx;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic model_reset();
    armed = 0; prev_de = 0; prev_vs_act = 0;
    mx = 0; my = 0; m_hlen = 0; m_sync = 0; m_sum = '0;
    pix_q.delete(); line_q.delete(); frm_q.delete();
  endtask

  // Outputs for a sample driven now appear two clock edges later.
  task automatic model_step(input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
    bit vs_act  = (vs == 1'b0);
    bit hs_act  = (hs == 1'b0);
    bit vs_edge = vs_act && !prev_vs_act;
    int len;
    if (!armed) begin
      if (vs_edge) begin
        armed = 1; mx = 0; my = 0; m_hlen = 0; m_sync = 0; m_sum = '0;
      end
    end else begin
      if (de) begin
        pix_q.push_back('{cyc + 2, sat(mx), sat(my), rgb});
        mx++;
        m_sum = m_sum + rgb;
        if (hs_act || vs_act) m_sync = 1;
      end
      if ((prev_de && !de) || (vs_edge && de)) begin
        len = sat(mx);
        line_q.push_back('{cyc + 2, len});
        if (len != HA) m_hlen = 1;
        my++;
        mx = 0;
      end
      if (vs_edge) begin
        frm_q.push_back('{cyc + 2, sat(my), m_hlen, sat(my) != VA, m_sync, m_sum});
        my = 0; m_hlen = 0; m_sync = 0; m_sum = '0;
      end
    end
    prev_de     = de;
    prev_vs_act = vs_act;
  endtask

  task automatic drive(input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
    @(negedge clk);
    bus_if.lcd_de  = de;
    bus_if.lcd_hs  = hs;
    bus_if.lcd_vs  = vs;
    bus_if.lcd_rgb = rgb;
    model_step(de, hs, vs, rgb);
  endtask

  function automatic logic [23:0] gen_rgb();
    logic [23:0] v;
    case (rgb_mode)
      0:       v = 24'(pidx);
      1:       v = 24'h000001;
      default: v = 24'($urandom);
    endcase
    pidx++;
    return v;
  endfunction

  task automatic blank(input int extra);
    drive(0, 1, 1, '0); drive(0, 1, 1, '0);
    drive(0, 0, 1, '0); drive(0, 0, 1, '0);
    for (int i = 0; i <= extra; i++) drive(0, 1, 1, '0);
  endtask

  task automatic send_line(input int len);
    for (int i = 0; i < len; i++) drive(1, 1, 1, gen_rgb());
    blank(int'($urandom_range(0, 2)));
  endtask

  task automatic vs_pulse();
    drive(0, 1, 1, '0);
    drive(0, 1, 0, '0); drive(0, 1, 0, '0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, '0);
    pidx = 0;
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_pix_valid"},   32'(bus_if.pix_valid),   0);
    check_val({pfx, "_pix_x"},       32'(bus_if.pix_x),       0);
    check_val({pfx, "_pix_y"},       32'(bus_if.pix_y),       0);
    check_val({pfx, "_pix_data"},    32'(bus_if.pix_data),    0);
    check_val({pfx, "_frame_done"},  32'(bus_if.frame_done),  0);
    check_val({pfx, "_frame_lines"}, 32'(bus_if.frame_lines), 0);
    check_val({pfx, "_line_len"},    32'(bus_if.line_len),    0);
    check_val({pfx, "_err_hlen"},    32'(bus_if.err_hlen),    0);
    check_val({pfx, "_err_vlen"},    32'(bus_if.err_vlen),    0);
    check_val({pfx, "_err_sync"},    32'(bus_if.err_sync),    0);
    check_val({pfx, "_frame_sum"},   32'(bus_if.frame_sum),   0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    model_reset();
    bus_if.lcd_de = 1'b0; bus_if.lcd_hs = 1'b1; bus_if.lcd_vs = 1'b1; bus_if.lcd_rgb = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle-by-cycle comparison of the DUT against the model's expected event queues.
  always @(negedge clk) begin
    if (rst_n) begin
      pix_t  p;
      frm_t  f;
      line_t l;
      bit    exp_v;
      logic [23:0] exp_sum;
      while (pix_q.size() > 0 && pix_q[0].cyc < cyc) void'(pix_q.pop_front());
      while (frm_q.size() > 0 && frm_q[0].cyc < cyc) void'(frm_q.pop_front());
      exp_v = (pix_q.size() > 0) && (pix_q[0].cyc == cyc);
      check_val("pix_valid", 32'(bus_if.pix_valid), 32'(exp_v));
      if (exp_v) begin
        p = pix_q.pop_front();
        check_val("pix_x",    32'(bus_if.pix_x),    32'(p.x));
        check_val("pix_y",    32'(bus_if.pix_y),    32'(p.y));
        check_val("pix_data", 32'(bus_if.pix_data), 32'(p.d));
      end
      exp_v = (frm_q.size() > 0) && (frm_q[0].cyc == cyc);
      check_val("frame_done", 32'(bus_if.frame_done), 32'(exp_v));
      if (exp_v) begin
        f = frm_q.pop_front();
`ifdef LCD_RX_CHECKSUM_EN
        exp_sum = f.sum;
`else
        exp_sum = '0;
`endif
        check_val("frame_lines", 32'(bus_if.frame_lines), 32'(f.lines));
        check_val("err_hlen",    32'(bus_if.err_hlen),    32'(f.hlen));
        check_val("err_vlen",    32'(bus_if.err_vlen),    32'(f.vlen));
        check_val("err_sync",    32'(bus_if.err_sync),    32'(f.sync));
        check_val("frame_sum",   32'(bus_if.frame_sum),   32'(exp_sum));
      end
      while (line_q.size() > 0 && line_q[0].cyc <= cyc) begin
        l = line_q.pop_front();
        if (l.cyc == cyc) check_val("line_len", 32'(bus_if.line_len), 32'(l.len));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.lcd_de = 1'b0; bus_if.lcd_hs = 1'b1; bus_if.lcd_vs = 1'b1; bus_if.lcd_rgb = '0;
    rgb_mode = 0;
    pidx     = 0;
    model_reset();
    #23 check_all_zero("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame: first VS only arms, second reports.
    vs_pulse();
    for (int i = 0; i < 4; i++) send_line(8);

    // Short second line.
    vs_pulse();
    send_line(8); send_line(7); send_line(8); send_line(8);

    // Five lines per frame.
    vs_pulse();
    for (int i = 0; i < 5; i++) send_line(8);

    // DE held high across the VS leading edge.
    vs_pulse();
    for (int i = 0; i < 3; i++) send_line(8);
    for (int i = 0; i < 5; i++) drive(1, 1, 1, gen_rgb());
    drive(1, 1, 0, gen_rgb());
    for (int i = 0; i < 3; i++) drive(1, 1, 1, gen_rgb());
    blank(1);
    for (int i = 0; i < 3; i++) send_line(8);

    // Reset mid-line, then lines before any VS must stay silent.
    vs_pulse();
    send_line(8);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, gen_rgb());
    pulse_reset();
    send_line(8); send_line(8);
    vs_pulse();
    for (int i = 0; i < 4; i++) send_line(8);

    // Checksum frame of 32 unit pixels.
    rgb_mode = 1;
    vs_pulse();
    for (int i = 0; i < 4; i++) send_line(8);

    // Random frames with random geometry and data.
    rgb_mode = 2;
    for (int f = 0; f < 6; f++) begin
      int nl;
      vs_pulse();
      nl = int'($urandom_range(3, 5));
      for (int i = 0; i < nl; i++) send_line(int'($urandom_range(6, 9)));
    end

    // Counter saturation on an over-long line.
    vs_pulse();
    send_line(4100);
    send_line(8);

    vs_pulse();
    for (int i = 0; i < 6; i++) drive(0, 1, 1, '0);

    check_val("pix_q_left",  32'(pix_q.size()),  0);
    check_val("frm_q_left",  32'(frm_q.size()),  0);
    check_val("line_q_left", 32'(line_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_rx_monitor.md
# lcd_rx_monitor

Receive-side monitor for the parallel RGB LCD interface (lcd_de / lcd_hs / lcd_vs / lcd_rgb) produced by the colour-bar generator. It sits on the pixel bus in the pixel-clock domain. It re-times the bus into pixel coordinates and streams valid pixels downstream. Per frame it reports measured geometry and geometry/sync errors, so generator output can be checked in simulation or on hardware.

## Interface
- H_ACTIVE, 800, expected DE-high pixels per line
- V_ACTIVE, 480, expected DE lines per frame
- HS_POL, 0, HS active level (0 = active-low)
- VS_POL, 0, VS active level (0 = active-low)
- sys_clk  in  1  pixel clock; all inputs sampled on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- lcd_de  in  1  data enable
- lcd_hs  in  1  horizontal sync
- lcd_vs  in  1  vertical sync
- lcd_rgb  in  24  pixel data {R,G,B}
- pix_valid  out  1  pixel strobe
- pix_x  out  12  column of current pixel, 0-based
- pix_y  out  12  row of current pixel, 0-based
- pix_data  out  24  pixel data
- frame_done  out  1  one-cycle pulse; frame statistics valid
- frame_lines  out  12  DE lines counted in the finished frame
- line_len  out  12  length of the most recent completed line
- err_hlen  out  1  any line in the finished frame had length ≠ H_ACTIVE
- err_vlen  out  1  frame_lines ≠ V_ACTIVE
- err_sync  out  1  DE was high while HS or VS was active in the finished frame
- frame_sum  out  24  additive checksum of the finished frame (see Configuration)

## Operation
- Input stage: de/hs/vs/rgb registered once (d1), plus a delayed copy (d2) for edge detection.
- Edge rules:
  - VS leading edge = d1 active, d2 inactive, per VS_POL.
  - DE fall = d2 high, d1 low.
- FSM with two states, reset state WAIT_VS:
  - WAIT_VS: pix_valid held 0; counters held at 0. On first VS leading edge -> IN_FRAME. No frame_done.
  - IN_FRAME:
    - While d1 DE is high: pix_valid=1, pix_data=d1 rgb, pix_x=x_cnt, pix_y=y_cnt; then x_cnt++.
    - On DE fall: line_len<=x_cnt; set hlen flag if x_cnt≠H_ACTIVE; x_cnt<=0; y_cnt++.
    - On VS leading edge: frame_done=1 for one cycle. Latch frame_lines<=y_cnt, err_hlen<=hlen flag, err_vlen<=(y_cnt≠V_ACTIVE), err_sync<=sync flag, frame_sum<=sum. Then clear y_cnt, flags and sum. Stay in IN_FRAME.
- Simultaneous DE fall and VS leading edge: close the line first. That line counts in frame_lines and its length check is included in err_hlen of the same frame_done.
- DE still high at VS leading edge: the partial line is closed as above, with its length checked. The DE-high overlap also sets err_sync.
- err_sync flag: set on any cycle with d1 DE high and HS or VS active.
- x_cnt and y_cnt saturate at 4095; no wrap.
- Reset mid-operation: all state cleared asynchronously; FSM re-enters WAIT_VS and re-arms on the next VS leading edge.
- lcd_hs is used only for the err_sync check. Line boundaries come from DE alone.

## Timing
- Reset values: all outputs 0; FSM in WAIT_VS.
- Pixel latency: lcd_de/lcd_rgb sampled at edge N -> pix_valid/pix_data/pix_x/pix_y registered and visible after edge N+1 (2 register stages).
- frame_done asserts the cycle after the VS leading edge is detected, i.e. 2 cycles after VS is sampled active. Statistics outputs update in the same cycle and hold until the next frame_done.
- line_len updates the cycle after the DE fall is detected.
- No backpressure: the downstream must accept one pixel per cycle.

## Configuration
- LCD_RX_CHECKSUM_EN defined:
  - 24-bit accumulator adds pix_data (mod 2^24) for every valid pixel.
  - Value latched to frame_sum at frame_done, then cleared.
- Not defined: the accumulator is not built and frame_sum is constant 0.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=4, HS_POL=VS_POL=0.
- Reset then a clean frame: 4 lines of 8 DE pixels with rgb = pixel index. Required: first VS only arms. Second VS gives frame_done=1 for one cycle, frame_lines=4, line_len=8, err_hlen=err_vlen=err_sync=0. Pixels carry pix_x 0..7 and pix_y 0..3 with 2-cycle latency.
- Line 2 is 7 pixels long. Required: at the next frame_done err_hlen=1, err_vlen=0; line_len=7 after line 2, returning to 8 after line 3.
- 5 lines per frame. Required: frame_lines=5, err_vlen=1.
- DE held high through a VS leading edge. Required: partial line counted in that frame, err_sync=1, frame_done still pulses once.
- sys_rst_n pulsed low mid-frame. Required: all outputs 0 asynchronously; no pix_valid until a VS leading edge is seen; the following full frame reports correct stats.
- With LCD_RX_CHECKSUM_EN: clean frame of 32 pixels with rgb = 0x000001. Required: frame_sum = 0x000020. Without the macro: frame_sum = 0.
